park_tr: RTL
============

Name: park_tr

Overview:
- Park transform stage that sits directly downstream of the Clark stage in the FOC current loop.
- Consumes the stationary-frame currents (ialpha, ibeta) together with the rotor electrical angle and produces rotating-frame currents (id, iq) for the PI controllers.
- Fully pipelined: one sample per clock, fixed latency, valid-strobe handshake identical in style to the Clark stage.

Parameters:
- None. All widths are fixed: 16-bit currents, 12-bit angle, Q1.14 sin/cos.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset; one clock (clk), asynchronous active-low reset (rstn).
- i_en  input  1  input sample valid strobe.
- i_theta  input  12  electrical angle, unsigned; 4096 counts = 2*pi.
- i_ialpha  input  16  signed alpha current.
- i_ibeta  input  16  signed beta current.
- o_en  output  1  output valid strobe.
- o_id  output  16  signed d-axis current.
- o_iq  output  16  signed q-axis current.

Behaviour:
- Reset: o_en=0, o_id=0, o_iq=0, all pipeline registers and valid flags 0. Reset is asynchronous and takes effect mid-stream; in-flight samples are discarded, with no spurious o_en after release.
- Math:
  - id = (ialpha*cos + ibeta*sin + 8192) >>> 14.
  - iq = (ibeta*cos - ialpha*sin + 8192) >>> 14.
  - sin/cos are signed 16-bit, amplitude 16384.
  - Products are 32-bit signed; sums are 33-bit signed; round-half-up before the arithmetic shift.
- Latency: o_en is asserted exactly 5 clocks after i_en is sampled high. Throughput is 1 sample per clock. Back-to-back i_en is allowed, and gaps are allowed.
- Pipeline:
  - s1: register ialpha/ibeta; present theta to sincos_lut.
  - s2: sincos_lut output registered (LUT latency 2 total, aligned with s2); data is delayed alongside.
  - s3: four products registered.
  - s4: two sums with rounding offset registered.
  - out: shift/limit, register outputs.
- Valid flag travels with the data; non-valid stages still compute but are ignored.
- Output hold: o_id/o_iq update only when the s4 valid is 1 and otherwise keep their last value. o_en is 1 for exactly one cycle per input strobe.
- sincos_lut:
  - Quarter-wave table T[k] = round(16384*sin(2*pi*k/4096)), k=0..1023. T[1024] is treated as 16384.
  - Quadrant q = theta[11:10], index x = theta[9:0]:
    - q0: sin=T[x], cos=T[1024-x].
    - q1: sin=T[1024-x], cos=-T[x].
    - q2: sin=-T[x], cos=-T[1024-x].
    - q3: sin=-T[1024-x], cos=T[x].
  - Boundary: x=0 on the 1024-x lookup yields 16384. Exact angles are 0 -> (0, 16384), 1024 -> (16384, 0), 2048 -> (0, -16384), 3072 -> (-16384, 0).
  - theta wraps naturally at 4095 -> 0; there is no special handling.

Optional Feature:
- PARK_SAT_EN.
- Defined: shifted results are clamped to [-32768, 32767] before registering.
- Undefined: results are truncated to the low 16 bits (two's-complement wrap). This saves logic when upstream ranges guarantee no overflow.

Decomposition:
- Shared package/header holds:
  - ANGLE_W=12, SC_FRAC=14, SC_AMP=16384, CUR_W=16.
  - Rounding constant 8192.
- Sub-module sincos_lut (clk, rstn, i_theta -> o_sin, o_cos, 2-cycle latency), reusable by the inverse Park stage.

Test Plan:
- theta=0, ialpha=1000, ibeta=0, single i_en pulse -> after 5 clocks o_en=1 for 1 cycle, o_id=1000, o_iq=0.
- theta=1024, ialpha=1000, ibeta=500 -> o_id=500, o_iq=-1000; theta=2048 with same inputs -> o_id=-1000, o_iq=-500.
- theta=512, ialpha=ibeta=32767:
  - PARK_SAT_EN defined -> o_id=32767, o_iq=0.
  - Macro undefined -> o_id=-19197, o_iq=0.
- Streaming: i_en high for 4096 consecutive cycles, theta ramping 0..4095, ialpha=ibeta=8000 -> 4096 consecutive o_en pulses, in order, each matching the reference model within +/-1 LSB.
- Gaps: i_en pulses spaced 3 cycles apart -> o_id/o_iq hold their values between o_en pulses.
- Reset: rstn pulled low 2 cycles after a burst of 3 i_en pulses -> outputs go to 0 immediately and no o_en follows. First post-reset sample appears 5 clocks after its i_en.

Source files
------------

// File: rtl/park_tr_pkg.sv
//------------------------------------------------------------------------------
// park_tr_pkg : shared widths, constants, quadrant encoding and helper
//               functions for the Park transform and its sin/cos table.
// Optional macro: PARK_SAT_EN (limit_cur clamps instead of wrapping)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package park_tr_pkg;

   localparam int ANGLE_W = 12;
   localparam int SC_FRAC = 14;
   localparam int SC_AMP  = 16384;
   localparam int CUR_W   = 16;
   localparam int SC_RND  = 8192;

   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quad_t;

   // Elaboration-time round(SC_AMP*sin(pi*k/2048)); angle held in Q30, Taylor series.
   function automatic logic [14:0] quarter_sin(input int k);
      longint x;
      longint x2;
      longint term;
      longint acc;
      x    = (64'sd3373259426 * k) / 2048;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -((term * x2) >>> 30) / ((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return 15'((acc * SC_AMP + (longint'(1) <<< 29)) >>> 30);
   endfunction

   function automatic logic signed [CUR_W-1:0] limit_cur(input logic signed [32:0] v);
      logic signed [32:0] sh;
      sh = v >>> SC_FRAC;
`ifdef PARK_SAT_EN
      if (sh > 33'sd32767)
         limit_cur = 16'sh7FFF;
      else if (sh < -33'sd32768)
         limit_cur = 16'sh8000;
      else
         limit_cur = sh[CUR_W-1:0];
`else
      limit_cur = sh[CUR_W-1:0];
`endif
   endfunction

endpackage

`default_nettype wire

// File: rtl/park_tr_sincos_lut.sv
//------------------------------------------------------------------------------
// park_tr_sincos_lut : quarter-wave sin/cos table, 2-cycle latency, Q1.14.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module park_tr_sincos_lut
   import park_tr_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [ANGLE_W-1:0]       i_theta,
   output logic signed [CUR_W-1:0]  o_sin,
   output logic signed [CUR_W-1:0]  o_cos
);

   logic [14:0]              w_rom [0:1024];
   logic [10:0]              w_idx_x;
   logic [10:0]              w_idx_c;
   logic signed [CUR_W-1:0]  w_tx;
   logic signed [CUR_W-1:0]  w_tc;
   logic signed [CUR_W-1:0]  w_sin;
   logic signed [CUR_W-1:0]  w_cos;

   quad_t                    r_quad;
   logic [14:0]              r_tx;
   logic [14:0]              r_tc;
   logic signed [CUR_W-1:0]  r_sin;
   logic signed [CUR_W-1:0]  r_cos;

   for (genvar k = 0; k <= 1024; k++) begin : g_rom
      assign w_rom[k] = quarter_sin(k);
   end

   // The complementary index reaches 1024 at x=0, which holds full scale.
   assign w_idx_x = {1'b0, i_theta[9:0]};
   assign w_idx_c = 11'd1024 - w_idx_x;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_quad <= QUAD_0;
         r_tx   <= '0;
         r_tc   <= '0;
         r_sin  <= '0;
         r_cos  <= '0;
      end else begin
         r_quad <= quad_t'(i_theta[11:10]);
         r_tx   <= w_rom[w_idx_x];
         r_tc   <= w_rom[w_idx_c];
         r_sin  <= w_sin;
         r_cos  <= w_cos;
      end
   end

   assign w_tx = {1'b0, r_tx};
   assign w_tc = {1'b0, r_tc};

   always_comb begin
      w_sin = w_tx;
      w_cos = w_tc;
      case (r_quad)
         QUAD_0: begin
            w_sin = w_tx;
            w_cos = w_tc;
         end
         QUAD_1: begin
            w_sin = w_tc;
            w_cos = -w_tx;
         end
         QUAD_2: begin
            w_sin = -w_tx;
            w_cos = -w_tc;
         end
         default: begin
            w_sin = -w_tc;
            w_cos = w_tx;
         end
      endcase
   end

   assign o_sin = r_sin;
   assign o_cos = r_cos;

endmodule

`default_nettype wire

// File: rtl/park_tr.sv
//------------------------------------------------------------------------------
// park_tr : pipelined Park transform (ialpha, ibeta, theta) -> (id, iq),
//           5-clock latency, one sample per clock.
// Optional macro: PARK_SAT_EN (clamp outputs instead of two's-complement wrap)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module park_tr
   import park_tr_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_en,
   input  logic [ANGLE_W-1:0]       i_theta,
   input  logic signed [CUR_W-1:0]  i_ialpha,
   input  logic signed [CUR_W-1:0]  i_ibeta,
   output logic                     o_en,
   output logic signed [CUR_W-1:0]  o_id,
   output logic signed [CUR_W-1:0]  o_iq
);

   logic signed [CUR_W-1:0]  w_sin;
   logic signed [CUR_W-1:0]  w_cos;

   logic                     r_s1_en;
   logic signed [CUR_W-1:0]  r_s1_ia;
   logic signed [CUR_W-1:0]  r_s1_ib;
   logic                     r_s2_en;
   logic signed [CUR_W-1:0]  r_s2_ia;
   logic signed [CUR_W-1:0]  r_s2_ib;
   logic                     r_s3_en;
   logic signed [31:0]       r_s3_ac;
   logic signed [31:0]       r_s3_bs;
   logic signed [31:0]       r_s3_bc;
   logic signed [31:0]       r_s3_as;
   logic                     r_s4_en;
   logic signed [32:0]       r_s4_d;
   logic signed [32:0]       r_s4_q;
   logic                     r_out_en;
   logic signed [CUR_W-1:0]  r_out_id;
   logic signed [CUR_W-1:0]  r_out_iq;

   // Table sees the raw angle so its 2-cycle output lines up with stage 2.
   park_tr_sincos_lut u_sincos_lut (
      .clk     (clk),
      .rstn    (rstn),
      .i_theta (i_theta),
      .o_sin   (w_sin),
      .o_cos   (w_cos)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_en  <= 1'b0;
         r_s1_ia  <= '0;
         r_s1_ib  <= '0;
         r_s2_en  <= 1'b0;
         r_s2_ia  <= '0;
         r_s2_ib  <= '0;
         r_s3_en  <= 1'b0;
         r_s3_ac  <= '0;
         r_s3_bs  <= '0;
         r_s3_bc  <= '0;
         r_s3_as  <= '0;
         r_s4_en  <= 1'b0;
         r_s4_d   <= '0;
         r_s4_q   <= '0;
         r_out_en <= 1'b0;
         r_out_id <= '0;
         r_out_iq <= '0;
      end else begin
         r_s1_en  <= i_en;
         r_s1_ia  <= i_ialpha;
         r_s1_ib  <= i_ibeta;

         r_s2_en  <= r_s1_en;
         r_s2_ia  <= r_s1_ia;
         r_s2_ib  <= r_s1_ib;

         r_s3_en  <= r_s2_en;
         r_s3_ac  <= 32'(r_s2_ia) * 32'(w_cos);
         r_s3_bs  <= 32'(r_s2_ib) * 32'(w_sin);
         r_s3_bc  <= 32'(r_s2_ib) * 32'(w_cos);
         r_s3_as  <= 32'(r_s2_ia) * 32'(w_sin);

         r_s4_en  <= r_s3_en;
         r_s4_d   <= 33'(r_s3_ac) + 33'(r_s3_bs) + 33'(SC_RND);
         r_s4_q   <= 33'(r_s3_bc) - 33'(r_s3_as) + 33'(SC_RND);

         // Outputs only move on a valid sample and hold otherwise.
         r_out_en <= r_s4_en;
         if (r_s4_en) begin
            r_out_id <= limit_cur(r_s4_d);
            r_out_iq <= limit_cur(r_s4_q);
         end
      end
   end

   assign o_en = r_out_en;
   assign o_id = r_out_id;
   assign o_iq = r_out_iq;

endmodule

`default_nettype wire
